// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// A grant lasts one burst: until req_last, MAX_BURST beats, or the requester drops req.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy,
    output logic [$clog2(MAX_BURST+1)-1:0]  burst_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   last_grant, last_grant_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic [CW-1:0]   count_q, count_n;

    logic            win_valid;
    logic [IW-1:0]   win_idx;
    logic            beat;
    logic            burst_end;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base);
        s = (s + off) % 32'(NUM_REQ);
        return IW'(s);
    endfunction

    // In GRANT, last_grant is the granted index, so one pointer serves both roles.
    // Scanning downward lets the lowest offset from last_grant+1 win.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            if (req[wrap_idx(last_grant, i)]) begin
                win_valid = 1'b1;
                win_idx   = wrap_idx(last_grant, i);
            end
        end
    end

    always_comb begin
        fifo_wr_data = req_data[32'(last_grant) * DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        grant_n      = grant_q;
        count_n      = count_q;
        req_ready    = '0;
        beat         = 1'b0;
        burst_end    = 1'b0;
        fifo_wr_en   = 1'b0;

        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_n          = GRANT;
                    last_grant_n     = win_idx;
                    grant_n          = '0;
                    grant_n[win_idx] = 1'b1;
                    count_n          = '0;
                end
            end
            GRANT: begin
                req_ready[last_grant] = !fifo_full;
                beat                  = req[last_grant] & !fifo_full;
                fifo_wr_en            = beat;
                // Dropping req ends the grant like a normal burst end, with no beat.
                burst_end = !req[last_grant] |
                            (beat & (req_last[last_grant] | (count_q == CW'(MAX_BURST - 1))));
                if (burst_end) begin
                    count_n = '0;
                    grant_n = '0;
                    if (win_valid) begin
                        last_grant_n     = win_idx;
                        grant_n[win_idx] = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (beat) begin
                    count_n = count_q + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            grant_q    <= '0;
            count_q    <= '0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            grant_q    <= grant_n;
            count_q    <= count_n;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state == GRANT);
    assign burst_count = count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter; expected write data is queued as stimulus is
// driven and compared whenever the arbiter strobes fifo_wr_en.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic [NR-1:0]     grant;
    logic              busy;
    logic [$clog2(MB+1)-1:0] burst_count;

    logic [DW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int base_cnt;

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant        (grant),
        .busy         (busy),
        .burst_count  (burst_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest queued beat and never hit a full FIFO.
    always @(negedge clk) begin
        if (reset === 1'b1 && fifo_wr_en === 1'b1) begin
            wr_cnt++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_extra observed=%0h expected=none", fifo_wr_data);
            end
            if (exp_q.size() != 0) chk("sb_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
            chk("no_write_when_full", 32'(fifo_full), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        tick();
        chk("sb_drained", exp_q.size(), 0);
        reset     = 1'b0;
        req       = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        req       = '1;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        #3;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", burst_count, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_ready", req_ready, 0);

        // 1: single requester, three-beat burst ending on req_last
        do_reset();
        base_cnt = wr_cnt;
        req = 4'b0001; put(0, 8'hA1); #2;
        chk("t1_idle_wr_en", fifo_wr_en, 0);
        chk("t1_idle_ready", req_ready, 0);
        tick();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy", busy, 1);
        chk("t1_count0", burst_count, 0);
        exp_q.push_back(8'hA1); #2;
        chk("t1_wr_en_a1", fifo_wr_en, 1);
        chk("t1_ready", req_ready, 4'b0001);
        tick();
        put(0, 8'hA2); exp_q.push_back(8'hA2); #2;
        chk("t1_count1", burst_count, 1);
        chk("t1_wr_en_a2", fifo_wr_en, 1);
        tick();
        put(0, 8'hA3); req_last = 4'b0001; exp_q.push_back(8'hA3); #2;
        chk("t1_count2", burst_count, 2);
        chk("t1_wr_en_a3", fifo_wr_en, 1);
        tick();
        req = '0; req_last = '0; #2;
        chk("t1_regrant", grant, 4'b0001);
        chk("t1_count_new", burst_count, 0);
        chk("t1_abandon_wr_en", fifo_wr_en, 0);
        tick(); #2;
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_writes", wr_cnt - base_cnt, 3);

        // 2: all requesting with single-beat bursts rotate without bubbles
        do_reset();
        req = 4'b1111; req_last = 4'b1111;
        for (int i = 0; i < NR; i++) put(i, 8'(8'h10 + i));
        #2;
        chk("t2_idle_wr_en", fifo_wr_en, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(8'(8'h10 + (k % NR))); #2;
            chk("t2_grant", grant, 4'b0001 << (k % NR));
            chk("t2_wr_en", fifo_wr_en, 1);
            chk("t2_count", burst_count, 0);
            tick();
        end
        req = '0; #2;
        chk("t2_next_grant", grant, 4'b0010);
        chk("t2_abandon_wr_en", fifo_wr_en, 0);
        tick(); #2;
        chk("t2_idle_busy", busy, 0);

        // 3: six beats without req_last are split by MAX_BURST into 4 + 2
        do_reset();
        base_cnt = wr_cnt;
        req = 4'b0100; req_last = '0; #2;
        tick();
        for (int k = 0; k < 6; k++) begin
            put(2, 8'(8'hB0 + k)); exp_q.push_back(8'(8'hB0 + k)); #2;
            chk("t3_count", burst_count, k % MB);
            chk("t3_grant", grant, 4'b0100);
            chk("t3_wr_en", fifo_wr_en, 1);
            tick();
        end
        chk("t3_count_end", burst_count, 2);
        req = '0; #2;
        chk("t3_abandon_wr_en", fifo_wr_en, 0);
        tick(); #2;
        chk("t3_idle_busy", busy, 0);
        chk("t3_writes", wr_cnt - base_cnt, 6);

        // 4: fifo_full stalls an open burst without losing the grant
        do_reset();
        req = 4'b0010; req_last = '0; put(1, 8'hC0); #2;
        tick();
        exp_q.push_back(8'hC0); #2;
        chk("t4_grant", grant, 4'b0010);
        chk("t4_wr_en", fifo_wr_en, 1);
        tick();
        fifo_full = 1'b1;
        repeat (3) begin
            #2;
            chk("t4_full_ready", req_ready, 0);
            chk("t4_full_wr_en", fifo_wr_en, 0);
            chk("t4_full_grant", grant, 4'b0010);
            chk("t4_full_count", burst_count, 1);
            tick();
        end
        fifo_full = 1'b0; put(1, 8'hC1); req_last = 4'b0010; exp_q.push_back(8'hC1); #2;
        chk("t4_resume_wr_en", fifo_wr_en, 1);
        chk("t4_resume_ready", req_ready, 4'b0010);
        chk("t4_resume_count", burst_count, 1);
        tick();
        req = '0; #2;
        chk("t4_regrant", grant, 4'b0010);
        chk("t4_regrant_count", burst_count, 0);
        tick(); #2;
        chk("t4_idle_busy", busy, 0);

        // 5: requester 0 abandons after one beat; grant moves to requester 3
        do_reset();
        base_cnt = wr_cnt;
        req = 4'b1001; req_last = '0; put(0, 8'hD0); put(3, 8'hD3); #2;
        tick();
        exp_q.push_back(8'hD0); #2;
        chk("t5_grant0", grant, 4'b0001);
        chk("t5_wr_en0", fifo_wr_en, 1);
        tick();
        req = 4'b1000; #2;
        chk("t5_abandon_wr_en", fifo_wr_en, 0);
        chk("t5_abandon_count", burst_count, 1);
        tick();
        chk("t5_writes_req0", wr_cnt - base_cnt, 1);
        exp_q.push_back(8'hD3); #2;
        chk("t5_grant3", grant, 4'b1000);
        chk("t5_count3", burst_count, 0);
        chk("t5_wr_en3", fifo_wr_en, 1);
        tick();
        req = '0; #2;
        tick(); #2;
        chk("t5_idle_busy", busy, 0);

        // 6: reset mid-burst clears everything at once; priority restarts at requester 0
        do_reset();
        req = 4'b0100; req_last = '0; put(2, 8'hE0); #2;
        tick();
        exp_q.push_back(8'hE0); #2;
        tick();
        put(2, 8'hE1); exp_q.push_back(8'hE1); #2;
        tick();
        chk("t6_pre_count", burst_count, 2);
        chk("t6_pre_grant", grant, 4'b0100);
        reset = 1'b0; #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wr_en", fifo_wr_en, 0);
        chk("t6_rst_count", burst_count, 0);
        chk("t6_rst_ready", req_ready, 0);
        req = 4'b1111; req_last = 4'b1111;
        for (int i = 0; i < NR; i++) put(i, 8'(8'h10 + i));
        tick();
        tick();
        reset = 1'b1; #2;
        chk("t6_idle_wr_en", fifo_wr_en, 0);
        tick();
        exp_q.push_back(8'h10); #2;
        chk("t6_first_grant", grant, 4'b0001);
        chk("t6_first_wr_en", fifo_wr_en, 1);
        tick();
        req = '0; #2;
        tick(); #2;
        chk("t6_idle_busy", busy, 0);

        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of a FIFO between NUM_REQ requesters using round-robin arbitration.
- A grant is held for a whole burst: until the requester's last beat, MAX_BURST beats, or the requester abandoning the burst.
- Sits in front of the FIFO write side, which advances its Gray write pointer on fifo_wr_en.
- Stalls all transfers while fifo_full is high.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, write data width.
- MAX_BURST, 4, maximum beats per grant (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request / data-valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  final beat of the burst.
- req_ready  output  NUM_REQ  beat accepted this cycle when req[i] is also high.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- grant  output  NUM_REQ  one-hot registered grant; all zero when idle.
- busy  output  1  high in GRANT state.
- burst_count  output  $clog2(MAX_BURST+1)  beats accepted in the current grant.

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE, grant=0, burst_count=0, busy=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0 and fifo_wr_en=0 while reset is low.
- States: IDLE, GRANT.
- Arbitration function: scan from index last_grant+1 upward, modulo NUM_REQ; the first i with req[i]=1 wins.
- IDLE:
  - If any req bit is set: next cycle state=GRANT, grant=onehot(winner), last_grant=winner, burst_count=0.
  - Otherwise remain in IDLE.
  - No beats are accepted in IDLE, so there is a fixed 1-cycle arbitration latency.
- GRANT, with g = granted index:
  - req_ready[g] = !fifo_full (combinational); all other req_ready bits are 0.
  - beat = req[g] & req_ready[g].
  - fifo_wr_en = beat; fifo_wr_data = req_data slice g (combinational). fifo_wr_data is don't-care when fifo_wr_en=0 but must not be X in simulation; drive the granted slice.
  - On a beat: burst_count increments.
  - Burst end = beat & (req_last[g] | burst_count==MAX_BURST-1).
    - On burst end, re-arbitrate the same cycle from last_grant=g.
    - If a winner exists: the next cycle grant=onehot(winner), burst_count=0, state stays GRANT, giving back-to-back bursts with no bubble. The current requester is eligible again but has the lowest priority.
    - If no winner: next state=IDLE, grant=0, burst_count=0.
  - Abandon: req[g]==0 in GRANT. No beat occurs, and the block behaves exactly as a burst end (re-arbitrate or go to IDLE).
  - fifo_full=1: no beat and the grant is held. burst_count is frozen and no timeout applies. Abandon still applies if req[g] drops.
  - MAX_BURST truncation: the next beats from that requester belong to a new grant obtained through normal round-robin. req_last is simply a marker and does not need to be reasserted.
  - MAX_BURST=1: every beat ends the grant.
- No beat is ever written without fifo_full==0; the FIFO's own overflow guard is not relied on.
- grant is at most one-hot at all times. burst_count never exceeds MAX_BURST-1 while registered.
- Reset asserted mid-burst: all state clears immediately and asynchronously. The partial burst is lost, and the arbiter does not resume it.

Test Plan:
1. Reset release, req=4'b0001, req_last on the 3rd beat, data 0xA1,0xA2,0xA3 → grant=0001 one cycle after req; fifo_wr_en high for 3 consecutive cycles carrying A1,A2,A3; then IDLE, grant=0, busy=0.
2. req=4'b1111 held, every beat req_last=1 → grant sequence 0001,0010,0100,1000,0001 on consecutive cycles; one write per cycle, no bubbles after the first grant.
3. Requester 2 sends 6 beats with no req_last, MAX_BURST=4, other req=0 → 4 writes; burst_count 0,1,2,3; re-grant to requester 2 with burst_count=0; 2 further writes.
4. Requester 1 granted, fifo_full=1 for 3 cycles after the 1st beat → req_ready[1]=0 and fifo_wr_en=0 for those 3 cycles, grant held, burst_count=1; writes resume after fifo_full falls.
5. Requesters 0 and 3 requesting; requester 0 drops req after 1 beat without req_last → grant moves to 1000 on the next cycle; exactly 1 write from requester 0.
6. reset pulled low while grant=0100 and burst_count=2 → grant=0, busy=0, fifo_wr_en=0 immediately; after release with req=1111, the first grant is 0001.
